// File: rtl/phase_accum.sv
// phase_accum: NCO phase accumulator. It has a pending-frequency handshake,
// a static phase offset, optional rounding to the output width and a
// one-deep registered output slot with valid/ready flow control.
module phase_accum #(
  parameter int PW       = 24,
  parameter int AW       = 12,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  input  logic          sync_i,
  input  logic [PW-1:0] freq_i,
  input  logic          freq_valid_i,
  output logic          freq_ready_o,
  input  logic [PW-1:0] offset_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [1:0]    quadrant_o,
  output logic [AW-3:0] angle_o,
  output logic          wrap_o
);

  // Rounding adds half an output LSB. It only makes sense when bits are dropped.
  localparam bit            RND     = ROUND_EN && (PW > AW);
  localparam int            RSH     = (PW > AW) ? (PW - AW - 1) : 0;
  localparam logic [PW-1:0] RND_ADD = RND ? (PW'(1) << RSH) : '0;

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] freq_q, freq_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          valid_q, valid_d;
  logic [1:0]    quad_q, quad_d;
  logic [AW-3:0] angle_q, angle_d;
  logic          wrap_q, wrap_d;

  logic          slot_free;
  logic          step;
  logic          hs;
  logic [PW:0]   sum;
  logic [AW-1:0] phase_top;

  // Step qualification, the accumulator adder with carry, and the output
  // phase. The output phase uses the pre-step accumulator so that the first
  // sample after a clear equals the offset.
  always_comb begin
    slot_free = !valid_q || ready_i;
    step      = run_i && !sync_i && slot_free;
    hs        = freq_valid_i && !pend_v_q;
    sum       = {1'b0, acc_q} + {1'b0, freq_q};
    phase_top = AW'((acc_q + offset_i + RND_ADD) >> (PW - AW));
  end

  // Next-state logic for the accumulator, frequency staging and output slot.
  always_comb begin
    acc_d    = acc_q;
    freq_d   = freq_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    valid_d  = valid_q;
    quad_d   = quad_q;
    angle_d  = angle_q;
    wrap_d   = wrap_q;

    if (sync_i) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[PW-1:0];
    end

    // A pending increment becomes active at a sample boundary. It also
    // becomes active at once while idle or clearing, because no sample is
    // in progress then.
    if (pend_v_q && (step || !run_i || sync_i)) begin
      freq_d   = pend_q;
      pend_v_d = 1'b0;
    end

    if (hs) begin
      pend_d   = freq_i;
      pend_v_d = 1'b1;
    end

    if (step) begin
      valid_d = 1'b1;
      quad_d  = phase_top[AW-1:AW-2];
      angle_d = phase_top[AW-3:0];
      wrap_d  = sum[PW];
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset, which overrides every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      freq_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      valid_q  <= 1'b0;
      quad_q   <= '0;
      angle_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      valid_q  <= valid_d;
      quad_q   <= quad_d;
      angle_q  <= angle_d;
      wrap_q   <= wrap_d;
    end
  end

  assign freq_ready_o = !pend_v_q;
  assign valid_o      = valid_q;
  assign quadrant_o   = quad_q;
  assign angle_o      = angle_q;
  assign wrap_o       = wrap_q;

endmodule

// File: doc/phase_accum.md
PHASE_ACCUM -- requirements
Module: phase_accum

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  PW, 24, phase accumulator width in bits.
  AW, 12, output phase width in bits: 2 quadrant bits plus AW-2 angle bits.
  ROUND_EN, 1, when 1, round accumulator to AW bits; when 0, truncate.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk_i  in  1  single clock; all logic on rising edge.
  rst_i  in  1  reset; synchronous, active-high.
  run_i  in  1  enable; accumulator steps only while high.
  sync_i  in  1  one-cycle pulse; clears accumulator phase to zero.
  freq_i  in  PW  frequency (phase increment) word.
  freq_valid_i  in  1  freq_i is offered.
  freq_ready_o  out  1  block can take a new freq_i.
  offset_i  in  PW  static phase offset added to the output, not accumulated.
  valid_o  out  1  output phase valid.
  ready_i  in  1  downstream (sincos) accepts the output phase.
  quadrant_o  out  2  phase bits [AW-1:AW-2]; feeds sincos quadrant_i.
  angle_o  out  AW-2  phase bits [AW-3:0]; feeds sincos angle_i.
  wrap_o  out  1  set with the sample whose step overflowed the accumulator.

Function
REQ-003 Internal state SHALL be:
- acc: PW-bit accumulator.
- freq: active increment.
- pend: pending increment plus pend_v flag.
- output register holding valid_o, quadrant_o, angle_o and wrap_o.
REQ-004 A step SHALL occur in a cycle when run_i=1, sync_i=0, and the output slot is free (valid_o=0 or ready_i=1).
REQ-005 On a step, acc SHALL become (acc + freq) mod 2^PW, and wrap SHALL be the carry out of that addition.
REQ-006 On a step, the output register SHALL load valid_o=1 and wrap_o=wrap.
REQ-007 On a step, {quadrant_o, angle_o} SHALL load the top AW bits of (acc_old + offset_i) mod 2^PW, where acc_old is acc before the step; the first sample after reset/sync is therefore phase offset.
REQ-008 With ROUND_EN=1, 2^(PW-AW-1) SHALL be added before taking the top bits, with modulo-2^AW wrap (phase 1.0 rounds to 0, quadrant 0).
REQ-009 Latency SHALL be 1 cycle: the sample appears on the outputs the cycle after its step.
REQ-010 When ready_i=0 and valid_o=1, all outputs SHALL hold stable and acc SHALL NOT advance; no sample is lost or duplicated.
REQ-011 When the output slot is free and no step occurs, valid_o SHALL go low in the next cycle.
REQ-012 A frequency handshake (freq_valid_i & freq_ready_o) SHALL write freq_i into pend and set pend_v; freq_ready_o SHALL equal !pend_v.
REQ-013 pend SHALL move to freq, and pend_v SHALL clear, in the cycle of the next step. That step uses the old freq; later steps use the new one, so the increment changes only at sample boundaries.
REQ-014 If run_i=0 or sync_i=1 while pend_v=1, pend SHALL move to freq immediately and pend_v SHALL clear.
REQ-015 sync_i=1 SHALL set acc to 0 and produce no step. The output register SHALL follow REQ-010/REQ-011.
REQ-016 sync_i SHALL take priority over a step. A handshake in the same cycle as sync_i SHALL still be accepted.
REQ-017 freq=0 SHALL produce a constant phase. freq=2^(PW-1) SHALL alternate between two phases 180 degrees apart, with wrap_o set on every second sample.
REQ-018 offset_i SHALL be sampled only at steps; changing it SHALL NOT change acc.

Reset
REQ-019 While rst_i=1, the following SHALL all be 0 on the next edge: acc, freq, pend, pend_v, valid_o, quadrant_o, angle_o, wrap_o.
REQ-020 freq_ready_o SHALL be 1 from the first cycle after reset.
REQ-021 rst_i SHALL override sync_i, run_i and any handshake in the same cycle, including a reset asserted mid-stall.

Verification (PW=16, AW=12, ROUND_EN=0 unless stated)
REQ-022 Load freq=0x0100, offset=0, run_i=1, ready_i=1:
  -> angle_o sequence 0, 16, 32, ...
  -> quadrant_o increments every 64 samples.
  -> wrap_o=1 on sample 256 only, then the pattern repeats.
REQ-023 With ready_i=0 for 5 cycles mid-run:
  -> outputs frozen.
  -> after release, the next sample continues +16 with no gap or repeat.
REQ-024 Load freq=0x0100, then freq=0x0200 while running:
  -> freq_ready_o=0 until the next step.
  -> exactly one more +16 sample, then +32 samples.
REQ-025 Assert sync_i with offset=0x4000 after 10 samples:
  -> the next sample is quadrant_o=1, angle_o=0.
  -> the sequence restarts from there.
REQ-026 Set ROUND_EN=1, freq=0x0008, offset=0:
  -> phase outputs 0, 1, 1, 2, 2, ...
  -> acc=0xFFF8 gives phase 0, quadrant 0.
REQ-027 Apply rst_i during a stall with pend_v=1:
  -> next cycle: all outputs 0 and freq_ready_o=1.
  -> accumulation restarts at phase 0 with freq=0.
